// File: rtl/div_result_bcd.sv
// Converts a divider's quotient and remainder to packed BCD with a serial
// double-dabble engine shared between the two operands.

module dd_add3 (
  input  logic [3:0] d,
  output logic [3:0] y
);
  assign y = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module div_result_bcd #(
  parameter int N = 16,
  parameter int D = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   q_in,
  input  logic [N-1:0]   r_in,
  input  logic           done_in,
  output logic [4*D-1:0] q_bcd,
  output logic [4*D-1:0] r_bcd,
  output logic           valid,
  output logic           busy,
  output logic           overrun
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [4*D-1:0] scr, adj, scr_nxt;
  logic [N-1:0]   sh, sh_nxt, r_lat;
  logic           done_prev;
  logic           rise;

  assign rise = done_in & ~done_prev;

  for (genvar g = 0; g < D; g++) begin : g_dig
    dd_add3 u_add3 (.d(scr[4*g +: 4]), .y(adj[4*g +: 4]));
  end

  // adj's top bit falls off the shift; 10^D > 2^N-1 keeps it zero.
  assign scr_nxt = {adj[4*D-2:0], sh[N-1]};
  assign sh_nxt  = {sh[N-2:0], 1'b0};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      scr       <= '0;
      sh        <= '0;
      r_lat     <= '0;
      q_bcd     <= '0;
      r_bcd     <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      done_prev <= 1'b1;
    end else begin
      done_prev <= done_in;
      case (state)
        IDLE: if (rise) begin
          sh      <= q_in;
          r_lat   <= r_in;
          scr     <= '0;
          cnt     <= CW'(N);
          busy    <= 1'b1;
          overrun <= 1'b0;
          state   <= CONV_Q;
        end
        CONV_Q, CONV_R: begin
          if (rise) overrun <= 1'b1;
          assert (!adj[4*D-1]);
          scr <= scr_nxt;
          sh  <= sh_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            scr <= '0;
            if (state == CONV_Q) begin
              q_bcd <= scr_nxt;
              sh    <= r_lat;
              cnt   <= CW'(N);
              state <= CONV_R;
            end else begin
              r_bcd <= scr_nxt;
              cnt   <= '0;
              state <= DONE;
            end
          end
        end
        // Two cycles here: raise valid, then drop valid and busy together.
        DONE: begin
          if (rise) overrun <= 1'b1;
          if (!valid) valid <= 1'b1;
          else begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd: latency, BCD values, overrun and reset.

module tb_div_result_bcd;
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] q_in, r_in;
  logic        done_in;
  logic [19:0] q_bcd, r_bcd;
  logic        valid, busy, overrun;
  int          checks = 0;
  int          errors = 0;

  div_result_bcd #(.N(16), .D(5)) dut (
    .clock(clock), .reset(reset), .q_in(q_in), .r_in(r_in), .done_in(done_in),
    .q_bcd(q_bcd), .r_bcd(r_bcd), .valid(valid), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Rising edge on done_in at negedge 0; valid expected at negedge 34.
  task automatic conv(input string tag, input logic [15:0] q, input logic [15:0] r,
                      input logic [19:0] eq, input logic [19:0] er);
    int lat = 0;
    int nv  = 0;
    @(negedge clock) done_in = 1'b0;
    @(negedge clock) begin q_in = q; r_in = r; done_in = 1'b1; end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (i == 1) begin
        chk({tag, "_busy_start"}, busy, 1);
        chk({tag, "_ovr_clear"}, overrun, 0);
      end
      if (valid) begin
        nv++;
        if (lat == 0) begin
          lat = i;
          chk({tag, "_q"}, q_bcd, eq);
          chk({tag, "_r"}, r_bcd, er);
          chk({tag, "_busy_valid"}, busy, 1);
        end
      end
      if (lat != 0 && i == lat + 1) chk({tag, "_busy_after"}, busy, 0);
    end
    chk({tag, "_latency"}, lat, 34);
    chk({tag, "_pulses"}, nv, 1);
  endtask

  // Second rising edge sampled on edge k after the accepted capture.
  task automatic ovr_test(input string tag, input int k);
    int lat = 0;
    int nv  = 0;
    @(negedge clock) done_in = 1'b0;
    @(negedge clock) begin q_in = 16'd123; r_in = 16'd45; done_in = 1'b1; end
    for (int i = 1; i <= 80; i++) begin
      @(negedge clock);
      if (valid) begin nv++; if (lat == 0) lat = i; end
      if (i == k - 1) done_in = 1'b0;
      if (i == k) begin q_in = 16'd999; r_in = 16'd1; done_in = 1'b1; end
    end
    chk({tag, "_pulses"}, nv, 1);
    chk({tag, "_latency"}, lat, 34);
    chk({tag, "_q"}, q_bcd, 20'h00123);
    chk({tag, "_r"}, r_bcd, 20'h00045);
    chk({tag, "_overrun"}, overrun, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int nv;
    reset = 1'b0; done_in = 1'b1; q_in = '0; r_in = '0;
    repeat (3) @(negedge clock);
    chk("rst_q", q_bcd, 0);
    chk("rst_r", r_bcd, 0);
    chk("rst_flags", {valid, busy, overrun}, 0);
    reset = 1'b1;
    // done_in high across release must not start a conversion
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (valid || busy) nv++;
    end
    chk("rel_high_idle", nv, 0);

    conv("c23_5", 16'd4, 16'd3, 20'h00004, 20'h00003);
    conv("c12345_678", 16'd18, 16'd141, 20'h00018, 20'h00141);
    nv = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (valid || busy) nv++;
    end
    chk("hold_no_retrig", nv, 0);

    conv("max", 16'd65535, 16'd0, 20'h65535, 20'h00000);
    conv("rem9999", 16'd0, 16'd9999, 20'h00000, 20'h09999);

    ovr_test("ovr10", 10);
    conv("ovr_next", 16'd7, 16'd8, 20'h00007, 20'h00008);
    ovr_test("ovr_done", 33);
    conv("ovr_next2", 16'd5, 16'd60000, 20'h00005, 20'h60000);

    // reset pulse on edge 20 of a conversion, done_in stays high
    @(negedge clock) done_in = 1'b0;
    @(negedge clock) begin q_in = 16'd321; r_in = 16'd54; done_in = 1'b1; end
    repeat (19) @(negedge clock);
    chk("mid_busy", busy, 1);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_q0", q_bcd, 0);
    chk("mid_r0", r_bcd, 0);
    chk("mid_flags", {valid, busy, overrun}, 0);
    reset = 1'b1;
    nv = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (valid || busy) nv++;
    end
    chk("mid_no_valid", nv, 0);
    conv("after_rst", 16'd7, 16'd2, 20'h00007, 20'h00002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
